wfg_stim_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the CORDIC sine stimulus generator. It drives the generator's enable and angular-increment inputs (ctrl_en, inc_val) and counts accepted AXI-Stream samples on the generator's output. From these counts it steps the increment from a start value to a stop value in single, repeat or triangle mode, producing chirp and step-sweep stimuli without software intervention. Gain and offset bypass this block and go straight to the generator.

---
 rtl/wfg_stim_sweep_pkg.sv | 34 +++
 rtl/wfg_stim_sweep_step.sv | 68 ++++++
 rtl/wfg_stim_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_wfg_stim_sweep_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wfg_stim_sweep_pkg.sv
// ---------------------------------------------------------------------------
// wfg_stim_sweep_pkg
// Shared types and constants for the stimulus frequency-sweep sequencer.
//   SWEEP_W       : width of the generator angular increment
//   sweep_mode_t  : sweep shape (single, repeat, triangle)
//   sweep_state_t : sequencer FSM states
//   decode_mode() : maps the raw 2-bit mode field onto sweep_mode_t
// ---------------------------------------------------------------------------
package wfg_stim_sweep_pkg;

    localparam int SWEEP_W = 16;

    typedef enum logic [1:0] {
        SINGLE   = 2'b00,
        REPEAT   = 2'b01,
        TRIANGLE = 2'b10
    } sweep_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } sweep_state_t;

    // The unused encoding 2'b11 falls back to a one-shot sweep.
    function automatic sweep_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return REPEAT;
            2'b10:   return TRIANGLE;
            default: return SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/wfg_stim_sweep_step.sv
// ---------------------------------------------------------------------------
// wfg_stim_sweep_step
// Combinational next-increment calculation for one sweep advance.
//   cur         : current increment
//   step        : step size (already forced non-zero by the caller)
//   start, stop : sweep end points
//   dir_up      : current leg direction (1 = increasing)
//   mode        : sweep shape
//   next        : increment to present after this advance
//   leg_end     : cur sits on the end point of the current leg
//   dir_up_next : direction after this advance
// ---------------------------------------------------------------------------
module wfg_stim_sweep_step
    import wfg_stim_sweep_pkg::*;
(
    input  logic [SWEEP_W-1:0] cur,
    input  logic [SWEEP_W-1:0] step,
    input  logic [SWEEP_W-1:0] start,
    input  logic [SWEEP_W-1:0] stop,
    input  logic               dir_up,
    input  sweep_mode_t        mode,
    output logic [SWEEP_W-1:0] next,
    output logic               leg_end,
    output logic               dir_up_next
);

    logic [SWEEP_W-1:0] hi;
    logic [SWEEP_W-1:0] lo;
    logic [SWEEP_W-1:0] target;
    logic [SWEEP_W-1:0] stepped;
    logic [SWEEP_W:0]   sum;
    logic [SWEEP_W:0]   diff;
    logic               move_up;

    // An upward leg always ends on the larger end point, a downward leg on
    // the smaller, so triangle legs need no extra bookkeeping.
    assign hi      = (start >= stop) ? start : stop;
    assign lo      = (start >= stop) ? stop  : start;
    assign leg_end = (cur == (dir_up ? hi : lo));

    // One extra bit keeps carry-out and borrow visible for the clamp.
    assign sum  = {1'b0, cur} + {1'b0, step};
    assign diff = {1'b0, cur} - {1'b0, step};

    // NOTE: every signal assigned in this block gets a value on every path
    // (defaults first), so no latch is inferred.
    always_comb begin
        move_up = dir_up;
        if (leg_end && mode == TRIANGLE)
            move_up = ~dir_up;
        dir_up_next = move_up;
        target      = move_up ? hi : lo;

        if (move_up)
            stepped = (sum > {1'b0, target}) ? target : sum[SWEEP_W-1:0];
        else
            stepped = (diff[SWEEP_W] || diff < {1'b0, target}) ? target : diff[SWEEP_W-1:0];

        next = stepped;
        if (leg_end) begin
            if (mode == SINGLE)
                next = cur;
            else if (mode == REPEAT)
                next = start;
        end
    end

endmodule

// File: rtl/wfg_stim_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// wfg_stim_sweep_ctrl
// Frequency-sweep sequencer for the CORDIC sine stimulus generator. Steps
// the generator increment from start to stop, dwelling a configured number
// of accepted output samples on each value.
//   clk, rst         : clock, asynchronous active-high reset
//   start_i, stop_i  : one-cycle sweep start / abort pulses
//   cfg_*_i          : sweep configuration, captured at start
//   sine_tvalid_i,
//   sine_tready_i    : monitored generator output handshake
//   ctrl_en_o        : generator enable
//   inc_val_o        : generator angular increment
//   busy_o           : sweep running
//   done_o           : one-cycle pulse at the end of a single-mode sweep
// ---------------------------------------------------------------------------
module wfg_stim_sweep_ctrl
    import wfg_stim_sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [15:0] cfg_start_inc_i,
    input  logic [15:0] cfg_stop_inc_i,
    input  logic [15:0] cfg_step_i,
    input  logic [15:0] cfg_dwell_i,
    input  logic [1:0]  cfg_mode_i,
    input  logic        sine_tvalid_i,
    input  logic        sine_tready_i,
    output logic        ctrl_en_o,
    output logic [15:0] inc_val_o,
    output logic        busy_o,
    output logic        done_o
);

    sweep_state_t       state;
    sweep_mode_t        mode_q;
    logic [SWEEP_W-1:0] start_q;
    logic [SWEEP_W-1:0] stop_q;
    logic [SWEEP_W-1:0] step_q;
    logic [SWEEP_W-1:0] dwell_q;
    logic [SWEEP_W-1:0] dwell_cnt;
    logic               dir_up_q;

    logic               accept;
    logic [SWEEP_W-1:0] next_inc;
    logic               leg_end;
    logic               dir_up_next;

    assign accept = sine_tvalid_i && sine_tready_i;

    wfg_stim_sweep_step u_step (
        .cur         (inc_val_o),
        .step        (step_q),
        .start       (start_q),
        .stop        (stop_q),
        .dir_up      (dir_up_q),
        .mode        (mode_q),
        .next        (next_inc),
        .leg_end     (leg_end),
        .dir_up_next (dir_up_next)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the configuration shadow registers are plain flops, so they are
    // reset along with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= SINGLE;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            dwell_cnt <= '0;
            dir_up_q  <= 1'b0;
            inc_val_o <= '0;
            ctrl_en_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (stop_i) begin
                // Abort wins over start and over a same-cycle handshake.
                state     <= IDLE;
                dwell_cnt <= '0;
                ctrl_en_o <= 1'b0;
                busy_o    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            start_q   <= cfg_start_inc_i;
                            stop_q    <= cfg_stop_inc_i;
                            step_q    <= (cfg_step_i  == '0) ? 16'd1 : cfg_step_i;
                            dwell_q   <= (cfg_dwell_i == '0) ? 16'd1 : cfg_dwell_i;
                            mode_q    <= decode_mode(cfg_mode_i);
                            dir_up_q  <= (cfg_start_inc_i <= cfg_stop_inc_i);
                            inc_val_o <= cfg_start_inc_i;
                            dwell_cnt <= '0;
                            ctrl_en_o <= 1'b1;
                            busy_o    <= 1'b1;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            if (dwell_cnt != dwell_q - 16'd1) begin
                                dwell_cnt <= dwell_cnt + 16'd1;
                            end else begin
                                dwell_cnt <= '0;
                                if (leg_end && mode_q == SINGLE) begin
                                    state     <= FINISH;
                                    done_o    <= 1'b1;
                                    ctrl_en_o <= 1'b0;
                                    busy_o    <= 1'b0;
                                end else begin
                                    inc_val_o <= next_inc;
                                    dir_up_q  <= dir_up_next;
                                end
                            end
                        end
                    end
                    FINISH:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wfg_stim_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wfg_stim_sweep_ctrl
// Self-checking bench for wfg_stim_sweep_ctrl. Stimulus tasks push the
// increment expected at each accepted sample into exp_q; the monitor pops
// and compares whenever the generator is enabled and a sample is accepted.
// ---------------------------------------------------------------------------
module tb_wfg_stim_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        stop_i;
    logic [15:0] cfg_start_inc_i;
    logic [15:0] cfg_stop_inc_i;
    logic [15:0] cfg_step_i;
    logic [15:0] cfg_dwell_i;
    logic [1:0]  cfg_mode_i;
    logic        sine_tvalid_i;
    logic        sine_tready_i;
    logic        ctrl_en_o;
    logic [15:0] inc_val_o;
    logic        busy_o;
    logic        done_o;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];

    wfg_stim_sweep_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .cfg_start_inc_i (cfg_start_inc_i),
        .cfg_stop_inc_i  (cfg_stop_inc_i),
        .cfg_step_i      (cfg_step_i),
        .cfg_dwell_i     (cfg_dwell_i),
        .cfg_mode_i      (cfg_mode_i),
        .sine_tvalid_i   (sine_tvalid_i),
        .sine_tready_i   (sine_tready_i),
        .ctrl_en_o       (ctrl_en_o),
        .inc_val_o       (inc_val_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: one expected increment per accepted generator sample.
    always @(negedge clk) begin
        if (done_o)
            done_cnt++;
        if (rst !== 1'b1 && ctrl_en_o && sine_tvalid_i && sine_tready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample_unexpected actual=%h required=none", inc_val_o);
            end else begin
                check("sample", inc_val_o, exp_q.pop_front());
            end
        end
    end

    task automatic set_cfg(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                           input logic [15:0] dw, input logic [1:0] m);
        cfg_start_inc_i = s;
        cfg_stop_inc_i  = e;
        cfg_step_i      = st;
        cfg_dwell_i     = dw;
        cfg_mode_i      = m;
    endtask

    task automatic push_n(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(v);
    endtask

    // Start pulse in cycle N; enable and first increment must appear in N+1.
    task automatic pulse_start(input string name, input logic [15:0] exp_inc);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        check({name, "_en"},   16'(ctrl_en_o), 16'd1);
        check({name, "_busy"}, 16'(busy_o),    16'd1);
        check({name, "_inc"},  inc_val_o,      exp_inc);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_o) break;
        end
        check({name, "_done"},   16'(done_o),       16'd1);
        check({name, "_en_off"}, 16'(ctrl_en_o),    16'd0);
        check({name, "_idle"},   16'(busy_o),       16'd0);
        check({name, "_drain"},  16'(exp_q.size()), 16'd0);
        @(negedge clk);
        check({name, "_pulse"},  16'(done_o),       16'd0);
    endtask

    // Let the queued samples through, then abort with the stream idle.
    task automatic drain_stop(input string name, input logic [15:0] hold);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        check({name, "_drain"}, 16'(exp_q.size()), 16'd0);
        sine_tvalid_i = 1'b0;
        stop_i        = 1'b1;
        @(posedge clk); #1 stop_i = 1'b0;
        @(negedge clk);
        check({name, "_en_off"}, 16'(ctrl_en_o), 16'd0);
        check({name, "_idle"},   16'(busy_o),    16'd0);
        check({name, "_nodone"}, 16'(done_o),    16'd0);
        check({name, "_hold"},   inc_val_o,      hold);
        sine_tvalid_i = 1'b1;
    endtask

    initial begin
        int done_before;
        rst           = 1'b1;
        start_i       = 1'b0;
        stop_i        = 1'b0;
        sine_tvalid_i = 1'b1;
        sine_tready_i = 1'b1;
        set_cfg(16'h0, 16'h0, 16'h0, 16'h0, 2'b00);
        #2;
        check("rst_en",   16'(ctrl_en_o), 16'd0);
        check("rst_inc",  inc_val_o,      16'h0000);
        check("rst_busy", 16'(busy_o),    16'd0);
        check("rst_done", 16'(done_o),    16'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Single up sweep, dwell 2.
        set_cfg(16'h0100, 16'h0400, 16'h0100, 16'd2, 2'b00);
        push_n(16'h0100, 2); push_n(16'h0200, 2); push_n(16'h0300, 2); push_n(16'h0400, 2);
        pulse_start("up", 16'h0100);
        wait_done("up");

        // Down sweep with overshoot clamp onto stop.
        set_cfg(16'h0400, 16'h0100, 16'h0200, 16'd1, 2'b00);
        push_n(16'h0400, 1); push_n(16'h0200, 1); push_n(16'h0100, 1);
        pulse_start("down", 16'h0400);
        wait_done("down");

        // Top-of-range clamp, no wrap through zero.
        set_cfg(16'hFF00, 16'hFFFF, 16'h0080, 16'd1, 2'b00);
        push_n(16'hFF00, 1); push_n(16'hFF80, 1); push_n(16'hFFFF, 1);
        pulse_start("top", 16'hFF00);
        wait_done("top");

        // Triangle: bounces between the end points, never done.
        done_before = done_cnt;
        set_cfg(16'h0010, 16'h0030, 16'h0010, 16'd1, 2'b10);
        push_n(16'h0010, 1); push_n(16'h0020, 1); push_n(16'h0030, 1); push_n(16'h0020, 1);
        push_n(16'h0010, 1); push_n(16'h0020, 1); push_n(16'h0030, 1); push_n(16'h0020, 1);
        pulse_start("tri", 16'h0010);
        drain_stop("tri", 16'h0010);
        check("tri_no_done", 16'(done_cnt - done_before), 16'd0);

        // Repeat: jumps back to start after each leg.
        done_before = done_cnt;
        set_cfg(16'h0010, 16'h0030, 16'h0010, 16'd1, 2'b01);
        push_n(16'h0010, 1); push_n(16'h0020, 1); push_n(16'h0030, 1);
        push_n(16'h0010, 1); push_n(16'h0020, 1); push_n(16'h0030, 1); push_n(16'h0010, 1);
        pulse_start("rep", 16'h0010);
        drain_stop("rep", 16'h0020);
        check("rep_no_done", 16'(done_cnt - done_before), 16'd0);

        // Stall: tready toggles, dwell 3; cfg edits mid-run are ignored.
        set_cfg(16'h0100, 16'h0200, 16'h0100, 16'd3, 2'b00);
        push_n(16'h0100, 3); push_n(16'h0200, 3);
        pulse_start("stall", 16'h0100);
        set_cfg(16'h5555, 16'h0001, 16'h0007, 16'd9, 2'b10);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1 sine_tready_i = ~sine_tready_i;
            if (done_o) break;
        end
        check("stall_done",  16'(done_o),       16'd1);
        check("stall_drain", 16'(exp_q.size()), 16'd0);
        check("stall_hold",  inc_val_o,         16'h0200);
        sine_tready_i = 1'b1;

        // Abort mid-run, dwell 4: last increment is held.
        set_cfg(16'h0100, 16'h0400, 16'h0100, 16'd4, 2'b00);
        push_n(16'h0100, 4); push_n(16'h0200, 2);
        pulse_start("abort", 16'h0100);
        drain_stop("abort", 16'h0200);

        // Start and stop together from IDLE: stays idle.
        set_cfg(16'h0777, 16'h0888, 16'h0001, 16'd1, 2'b00);
        @(posedge clk); #1 start_i = 1'b1; stop_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0; stop_i = 1'b0;
        @(negedge clk);
        check("both_en",   16'(ctrl_en_o), 16'd0);
        check("both_busy", 16'(busy_o),    16'd0);
        check("both_hold", inc_val_o,      16'h0200);
        @(negedge clk); @(negedge clk);
        check("both_still_idle", 16'(busy_o), 16'd0);

        // Step 0 and dwell 0 act as 1; mode 11 acts as single.
        set_cfg(16'h0005, 16'h0007, 16'h0000, 16'h0000, 2'b11);
        push_n(16'h0005, 1); push_n(16'h0006, 1); push_n(16'h0007, 1);
        pulse_start("zero", 16'h0005);
        wait_done("zero");

        // Degenerate single sweep: start == stop, done after dwell samples.
        set_cfg(16'h0050, 16'h0050, 16'h0010, 16'd2, 2'b00);
        push_n(16'h0050, 2);
        pulse_start("flat", 16'h0050);
        wait_done("flat");

        // Asynchronous reset mid-run, then a clean restart.
        set_cfg(16'h0100, 16'h0400, 16'h0100, 16'd2, 2'b00);
        push_n(16'h0100, 2); push_n(16'h0200, 1);
        pulse_start("pre_rst", 16'h0100);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        check("pre_rst_drain", 16'(exp_q.size()), 16'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_en",   16'(ctrl_en_o), 16'd0);
        check("arst_inc",  inc_val_o,      16'h0000);
        check("arst_busy", 16'(busy_o),    16'd0);
        check("arst_done", 16'(done_o),    16'd0);
        @(negedge clk); #2 rst = 1'b0;
        push_n(16'h0100, 2); push_n(16'h0200, 2); push_n(16'h0300, 2); push_n(16'h0400, 2);
        pulse_start("restart", 16'h0100);
        wait_done("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
